fft_butterfly_cmul: RTL and testbench

Radix-2 decimation-in-time butterfly for the CWT FFT datapath. It sits directly downstream of the per-stage twiddle ROMs. It drives the ROM address from an incoming twiddle index and aligns the registered ROM outputs with delayed operands. It then computes A ± B·W with a 3-cycle fully pipelined latency and saturating 16-bit outputs. One butterfly is accepted per clock with no back-pressure.

---
 rtl/fft_butterfly_cmul.sv | 117 +++++++++++
 tb/tb_fft_butterfly_cmul.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_cmul.sv
// fft_butterfly_cmul: radix-2 DIT butterfly X/Y = A +/- B*W, 3-stage pipeline, Q8 twiddles, saturating outputs
module fft_butterfly_cmul #(
    parameter int DW = 16,
    parameter int TW = 16,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic [AW-1:0]        tw_idx,
    output logic [AW-1:0]        tw_addr,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 ovf
);
    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam int QW = SW - 8;
    localparam int RW = QW + 1;
    localparam logic signed [RW-1:0] MAXV = RW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(1 <<< (DW - 1)));

    logic                 v1, v2;
    logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im, a2_re, a2_im;
    logic signed [QW-1:0] p_re, p_im;
    logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [SW-1:0] s_re, s_im;
    logic signed [RW-1:0] sx_re, sx_im, sy_re, sy_im;

    // the ROM registers the address itself, so its data lines up with stage 1
    assign tw_addr = tw_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            a1_re <= '0;
            a1_im <= '0;
            b1_re <= '0;
            b1_im <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1_re <= a_re;
                a1_im <= a_im;
                b1_re <= b_re;
                b1_im <= b_im;
            end
        end
    end

    assign m_rr = PW'(b1_re) * PW'(tw_re);
    assign m_ii = PW'(b1_im) * PW'(tw_im);
    assign m_ri = PW'(b1_re) * PW'(tw_im);
    assign m_ir = PW'(b1_im) * PW'(tw_re);
    assign s_re = SW'(m_rr) - SW'(m_ii);
    assign s_im = SW'(m_ri) + SW'(m_ir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            p_re  <= '0;
            p_im  <= '0;
            a2_re <= '0;
            a2_im <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                p_re  <= QW'(s_re >>> 8);
                p_im  <= QW'(s_im >>> 8);
                a2_re <= a1_re;
                a2_im <= a1_im;
            end
        end
    end

    assign sx_re = RW'(a2_re) + RW'(p_re);
    assign sx_im = RW'(a2_im) + RW'(p_im);
    assign sy_re = RW'(a2_re) - RW'(p_re);
    assign sy_im = RW'(a2_im) - RW'(p_im);

    function automatic logic oob(input logic signed [RW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [RW-1:0] v);
        return (v > MAXV) ? MAXV[DW-1:0] : (v < MINV) ? MINV[DW-1:0] : v[DW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            out_valid <= v2;
            ovf       <= v2 && (oob(sx_re) || oob(sx_im) || oob(sy_re) || oob(sy_im));
            if (v2) begin
                x_re <= sat(sx_re);
                x_im <= sat(sx_im);
                y_re <= sat(sy_re);
                y_im <= sat(sy_im);
            end
        end
    end
endmodule

// File: tb/tb_fft_butterfly_cmul.sv
// tb_fft_butterfly_cmul: directed checks of the butterfly against hand values and a behavioural model.
module tb_fft_butterfly_cmul;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [4:0]  tw_idx = '0, tw_addr;
    logic [15:0] tw_re, tw_im;
    logic        out_valid, ovf;
    logic [15:0] x_re, x_im, y_re, y_im;
    logic [15:0] rom_re [32];
    logic [15:0] rom_im [32];
    int tests = 0, fails = 0;

    typedef struct packed {
        logic [15:0] xr, xi, yr, yi;
        logic        ov;
    } res_t;

    fft_butterfly_cmul dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_idx(tw_idx), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // twiddle ROM: one-cycle registered read, no reset
    always @(posedge clk) begin
        tw_re <= rom_re[tw_addr];
        tw_im <= rom_im[tw_addr];
    end

    function automatic res_t model(input logic [15:0] ar, ai, br, bi, wr, wi);
        longint sar, sai, sbr, sbi, swr, swi, pr, pi;
        longint v [4];
        logic [15:0] o [4];
        res_t r;
        sar = longint'($signed(ar)); sai = longint'($signed(ai));
        sbr = longint'($signed(br)); sbi = longint'($signed(bi));
        swr = longint'($signed(wr)); swi = longint'($signed(wi));
        pr = (sbr * swr - sbi * swi) >>> 8;
        pi = (sbr * swi + sbi * swr) >>> 8;
        v[0] = sar + pr; v[1] = sai + pi; v[2] = sar - pr; v[3] = sai - pi;
        r.ov = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] > 32767) begin o[i] = 16'h7FFF; r.ov = 1'b1; end
            else if (v[i] < -32768) begin o[i] = 16'h8000; r.ov = 1'b1; end
            else o[i] = 16'(v[i]);
        end
        r.xr = o[0]; r.xi = o[1]; r.yr = o[2]; r.yi = o[3];
        return r;
    endfunction

    task automatic drive(input logic [15:0] ar, ai, br, bi, input logic [4:0] idx);
        @(negedge clk);
        in_valid = 1'b1; a_re = ar; a_im = ai; b_re = br; b_im = bi; tw_idx = idx;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; tw_idx = 5'd31;
    endtask

    task automatic test_reset();
        tw_idx = 5'd19;
        @(negedge clk);
        tests++;
        if ({out_valid, ovf, x_re, x_im, y_re, y_im} !== 66'd0)
            $display("FAIL reset_state: got %h expected 0", {out_valid, ovf, x_re, x_im, y_re, y_im});
        tests++;
        if (tw_addr !== 5'd19) $display("FAIL addr_in_reset: got %0d expected 19", tw_addr);
        if (tw_addr !== 5'd19) fails++;
        if ({out_valid, ovf, x_re, x_im, y_re, y_im} !== 66'd0) fails++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        res_t exp = {16'd120, 16'hFFEC, 16'd80, 16'hFFB0, 1'b0};
        drive(16'd100, 16'hFFCE, 16'd20, 16'd30, 5'd0);
        idle();
        tw_idx = 5'd6;
        #1;
        tests++;
        if (tw_addr !== 5'd6) begin fails++; $display("FAIL addr_follow: got %0d expected 6", tw_addr); end
        idle();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early: out_valid got %b expected 0", out_valid); end
        @(negedge clk);
        tests++;
        if ({out_valid, x_re, x_im, y_re, y_im, ovf} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL identity: got %h expected %h", {out_valid, x_re, x_im, y_re, y_im, ovf}, {1'b1, exp});
        end
    endtask

    task automatic test_rotation();
        res_t exp = {16'd7, 16'hFFFB, 16'hFFF9, 16'd5, 1'b0};
        drive(16'd0, 16'd0, 16'd5, 16'd7, 5'd1);
        idle(); idle();
        @(negedge clk);
        tests++;
        if ({out_valid, x_re, x_im, y_re, y_im, ovf} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL rotation: got %h expected %h", {out_valid, x_re, x_im, y_re, y_im, ovf}, {1'b1, exp});
        end
    endtask

    task automatic test_floor();
        res_t exp = {16'hFFFF, 16'd0, 16'd1, 16'd0, 1'b0};
        drive(16'd0, 16'd0, 16'd1, 16'd0, 5'd2);
        idle(); idle();
        @(negedge clk);
        tests++;
        if ({out_valid, x_re, x_im, y_re, y_im, ovf} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL floor: got %h expected %h", {out_valid, x_re, x_im, y_re, y_im, ovf}, {1'b1, exp});
        end
    endtask

    task automatic test_saturation();
        res_t exp = {16'h7FFF, 16'h8000, 16'd0, 16'd0, 1'b1};
        drive(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 5'd0);
        idle(); idle();
        @(negedge clk);
        tests++;
        if ({out_valid, x_re, x_im, y_re, y_im, ovf} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL saturation: got %h expected %h", {out_valid, x_re, x_im, y_re, y_im, ovf}, {1'b1, exp});
        end
        @(negedge clk);
        tests++;
        if ({out_valid, ovf, x_re} !== {2'b00, 16'h7FFF}) begin
            fails++;
            $display("FAIL ovf_pulse_hold: got %h expected %h", {out_valid, ovf, x_re}, {2'b00, 16'h7FFF});
        end
    endtask

    task automatic test_zero_twiddle();
        res_t exp = {16'd123, 16'hFE38, 16'd123, 16'hFE38, 1'b0};
        drive(16'd123, 16'hFE38, 16'd999, 16'h8000, 5'd30);
        idle(); idle();
        @(negedge clk);
        tests++;
        if ({out_valid, x_re, x_im, y_re, y_im, ovf} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL zero_twiddle: got %h expected %h", {out_valid, x_re, x_im, y_re, y_im, ovf}, {1'b1, exp});
        end
    endtask

    task automatic test_back_to_back(input bit bub);
        res_t ex [64];
        logic vh [64];
        res_t got;
        int nc = bub ? 56 : 28;
        int k = 0;
        logic [15:0] ar, ai, br, bi;
        for (int c = 0; c < nc + 3; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                tests++;
                if (out_valid !== vh[c-3]) begin
                    fails++;
                    $display("FAIL stream_valid c=%0d bub=%0d: got %b expected %b", c, bub, out_valid, vh[c-3]);
                end
                if (vh[c-3]) begin
                    got = {x_re, x_im, y_re, y_im, ovf};
                    tests++;
                    if (got !== ex[c-3]) begin
                        fails++;
                        $display("FAIL stream_data c=%0d bub=%0d: got %h expected %h", c, bub, got, ex[c-3]);
                    end
                end
            end
            if (c < nc && (!bub || c % 2 == 0)) begin
                ar = 16'(k * 2311 - 30000); ai = 16'(20000 - k * 1777);
                br = 16'(k * 997 - 12000);  bi = 16'(k * 3001 - 40000);
                in_valid = 1'b1; a_re = ar; a_im = ai; b_re = br; b_im = bi; tw_idx = 5'(k);
                ex[c] = model(ar, ai, br, bi, rom_re[k], rom_im[k]);
                vh[c] = 1'b1;
                k++;
            end else begin
                in_valid = 1'b0; tw_idx = 5'(c); vh[c] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t exp = {16'd4, 16'd6, 16'hFFFE, 16'hFFFE, 1'b0};
        drive(16'd500, 16'd600, 16'd7, 16'd8, 5'd0);
        drive(16'd501, 16'd601, 16'd7, 16'd8, 5'd0);
        drive(16'd502, 16'd602, 16'd7, 16'd8, 5'd0);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0; in_valid = 1'b0; tw_idx = 5'd7;
        #1;
        tests++;
        if ({out_valid, ovf, x_re, x_im, y_re, y_im} !== 66'd0) begin
            fails++;
            $display("FAIL mid_reset_clear: got %h expected 0", {out_valid, ovf, x_re, x_im, y_re, y_im});
        end
        tests++;
        if (tw_addr !== 5'd7) begin fails++; $display("FAIL mid_reset_addr: got %0d expected 7", tw_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL discard_%0d: got %b expected 0", i, out_valid); end
        end
        drive(16'd1, 16'd2, 16'd3, 16'd4, 5'd0);
        idle(); idle();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_early: got %b expected 0", out_valid); end
        @(negedge clk);
        tests++;
        if ({out_valid, x_re, x_im, y_re, y_im, ovf} !== {1'b1, exp}) begin
            fails++;
            $display("FAIL post_reset: got %h expected %h", {out_valid, x_re, x_im, y_re, y_im, ovf}, {1'b1, exp});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = (i < 28) ? 16'(300 - i * 23) : 16'd0;
            rom_im[i] = (i < 28) ? 16'(i * 17 - 200) : 16'd0;
        end
        rom_re[0] = 16'h0100; rom_im[0] = 16'h0000;
        rom_re[1] = 16'h0000; rom_im[1] = 16'hFF00;
        rom_re[2] = 16'hFF4A; rom_im[2] = 16'h0000;
        test_reset();
        test_identity();
        test_rotation();
        test_floor();
        test_saturation();
        test_zero_twiddle();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
